// File: rtl/circuit_unit.sv
// circuit_unit: pipelined sum-of-squares accumulator.
//
// Each enabled cycle captures a signed 32-bit sample. The next cycle
// squares it. The cycle after that adds the square into a W-bit running
// total, which is driven on y straight from a register.
//
// Optional build macro: CIRCUIT_SATURATE_EN
//   undefined (default) - accumulator wraps modulo 2^W
//   defined             - accumulator clamps at 2^W-1 and stays there
//                         until reset
// Pipeline timing is the same in both builds.
module circuit_unit #(
  parameter int W = 96          // accumulator / output width, must be >= 64
) (
  input  logic         clk,
  input  logic         rst,     // synchronous, active-low
  input  logic         en,      // sample-valid strobe
  input  logic [31:0]  r,       // two's-complement sample
  output logic [W-1:0] y        // running sum of squares, unsigned
);

  // Stage 1: captured sample and its valid flag.
  logic [31:0] r_q;
  logic        v1;

  // Stage 2: registered square and its valid flag.
  logic [63:0] p_q;
  logic        v2;

  // Accumulator register and its combinational next value.
  logic [W-1:0] acc_reg;
  logic [W-1:0] acc_next;

  // Sign-extend to 64 bits before squaring, so the full signed 32x32
  // product lands in 64 bits. (-2^31)^2 = 2^62 fits with no overflow.
  logic signed [63:0] r_ext;
  logic signed [63:0] sq;

  assign r_ext = {{32{r_q[31]}}, r_q};
  assign sq    = r_ext * r_ext;

  // Stage 1: take the sample on every enabled edge.
  // r is ignored entirely while en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= 32'd0;
      v1  <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        r_q <= r;
      end
    end
  end

  // Stage 2: square the captured sample. The square is never negative,
  // so it is held as a 64-bit unsigned value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q <= 64'd0;
      v2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p_q <= 64'(sq);
      end
    end
  end

`ifdef CIRCUIT_SATURATE_EN
  // The add is one bit wider than the accumulator, so the carry-out
  // flags overflow. On overflow the result clamps to all-ones. Once the
  // total is all-ones, any later non-zero add overflows again, so the
  // total stays pinned at all-ones.
  logic [W:0] sum_ext;

  // Saturating next-value computation.
  always_comb begin
    sum_ext  = (W+1)'(acc_reg) + (W+1)'(p_q);
    acc_next = sum_ext[W] ? {W{1'b1}} : sum_ext[W-1:0];
  end
`else
  // Plain wrap-around add, modulo 2^W.
  always_comb begin
    acc_next = acc_reg + W'(p_q);
  end
`endif

  // Stage 3: fold a valid square into the running total.
  // The total holds whenever the pipeline is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (v2) begin
      acc_reg <= acc_next;
    end
  end

  assign y = acc_reg;

endmodule

// File: tb/tb_circuit_unit.sv
// Testbench for circuit_unit.
//
// Two instances share the same stimulus: the default W=96 and a W=64
// copy that exercises the overflow cases. Expected values come either
// from constants or from a behavioural model.
//
// The model keeps a list of accepted samples, each tagged with the edge
// that accepted it. Any reset edge clears the whole list. After edge c,
// the expected y is the sum of the squares of surviving samples accepted
// at or before edge c-2. That sum is then wrapped, or clamped when
// CIRCUIT_SATURATE_EN is defined.
module tb_circuit_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] r;
  logic [95:0] y96;
  logic [63:0] y64;

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;

  typedef struct {
    int          eidx;
    logic [63:0] sq;
  } ent_t;

  ent_t q[$];

  circuit_unit dut96 (
    .clk(clk),
    .rst(rst),
    .en (en),
    .r  (r),
    .y  (y96)
  );

  circuit_unit #(.W(64)) dut64 (
    .clk(clk),
    .rst(rst),
    .en (en),
    .r  (r),
    .y  (y64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected accumulator value for a given width, after the latest edge.
  function automatic logic [127:0] model_y(input int w);
    logic [127:0] s;
    logic [127:0] lim;
    s   = '0;
    lim = 128'd1 << w;
    foreach (q[i]) begin
      if (q[i].eidx + 2 <= cyc) begin
        s = s + 128'(q[i].sq);
      end
    end
`ifdef CIRCUIT_SATURATE_EN
    if (s >= lim) begin
      return lim - 128'd1;
    end
    return s;
`else
    return s & (lim - 128'd1);
`endif
  endfunction

  // Square of a 32-bit two's-complement sample, from plain arithmetic.
  function automatic logic [63:0] square_of(input logic [31:0] v);
    longint sv;
    sv = longint'($signed(v));
    return 64'(sv * sv);
  endfunction

  // Drive one clock edge and record what the block should have accepted.
  // Outputs are then sampled 1 time unit after the edge.
  task automatic tick(input logic rst_v, input logic en_v, input logic [31:0] r_v);
    ent_t e;
    rst = rst_v;
    en  = en_v;
    r   = r_v;
    @(posedge clk);
    cyc++;
    if (!rst_v) begin
      q.delete();
    end else if (en_v) begin
      e.eidx = cyc;
      e.sq   = square_of(r_v);
      q.push_back(e);
    end
    #1;
  endtask

  // Both instances compared against the model; tag names the check.
  task automatic check_model(input string tag);
    tests_run++;
    if (128'(y96) !== model_y(96)) begin
      failed++;
      $display("FAIL %s y96 cyc=%0d got=%0d exp=%0d", tag, cyc, y96, model_y(96));
    end
    tests_run++;
    if (128'(y64) !== model_y(64)) begin
      failed++;
      $display("FAIL %s y64 cyc=%0d got=%0d exp=%0d", tag, cyc, y64, model_y(64));
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 32'd5);
      tests_run++;
      if (y96 !== 96'd0) begin
        failed++;
        $display("FAIL reset_hold got=%0d exp=0", y96);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, $urandom);
      tests_run++;
      if (y96 !== 96'd0 || y64 !== 64'd0) begin
        failed++;
        $display("FAIL reset_idle got=%0d/%0d exp=0", y96, y64);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single;
    logic [95:0] exp_seq [6];
    exp_seq = '{96'd0, 96'd0, 96'd9, 96'd9, 96'd9, 96'd34};
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        tick(1'b1, 1'b1, 32'd3);
      end else if (i == 3) begin
        tick(1'b1, 1'b1, -32'sd5);
      end else begin
        tick(1'b1, 1'b0, $urandom);
      end
      tests_run++;
      if (y96 !== exp_seq[i]) begin
        failed++;
        $display("FAIL single step=%0d got=%0d exp=%0d", i, y96, exp_seq[i]);
      end
    end
    $display("[TB] test_single done");
  endtask

  task automatic test_back_to_back;
    logic [95:0] exp_seq [6];
    logic [31:0] rs [3];
    exp_seq = '{96'd0, 96'd0, 96'd4190209, 96'd8384513, 96'd8384513, 96'd8384513};
    rs = '{32'd2047, -32'sd2048, 32'd0};
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        tick(1'b1, 1'b1, rs[i]);
      end else begin
        tick(1'b1, 1'b0, $urandom);
      end
      tests_run++;
      if (y96 !== exp_seq[i]) begin
        failed++;
        $display("FAIL b2b step=%0d got=%0d exp=%0d", i, y96, exp_seq[i]);
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_pulsed_random;
    longint sw_sum;
    int     rv;
    sw_sum = 0;
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 100; i++) begin
      rv = int'($urandom_range(0, 4094)) - 2047;
      sw_sum += longint'(rv) * longint'(rv);
      tick(1'b1, 1'b1, 32'(rv));
      check_model("pulsed_en");
      tick(1'b1, 1'b0, $urandom);
      check_model("pulsed_idle");
    end
    tick(1'b1, 1'b0, $urandom);
    tick(1'b1, 1'b0, $urandom);
    tests_run++;
    if (y96 !== 96'(sw_sum)) begin
      failed++;
      $display("FAIL pulsed_final got=%0d exp=%0d", y96, sw_sum);
    end
    $display("[TB] test_pulsed_random done, sum=%0d", sw_sum);
  endtask

  task automatic test_random_stream;
    logic e;
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 200; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      tick(1'b1, e, $urandom);
      check_model("rand_stream");
    end
    $display("[TB] test_random_stream done");
  endtask

  task automatic test_overflow;
    logic [63:0] exp_seq [7];
`ifdef CIRCUIT_SATURATE_EN
    exp_seq = '{64'd0, 64'd0, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'hC000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
`else
    exp_seq = '{64'd0, 64'd0, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'hC000_0000_0000_0000, 64'd0, 64'd1};
`endif
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        tick(1'b1, 1'b1, 32'h8000_0000);
      end else if (i == 4) begin
        tick(1'b1, 1'b1, 32'd1);
      end else begin
        tick(1'b1, 1'b0, $urandom);
      end
      tests_run++;
      if (y64 !== exp_seq[i]) begin
        failed++;
        $display("FAIL overflow64 step=%0d got=%h exp=%h", i, y64, exp_seq[i]);
      end
      check_model("overflow");
    end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_reset_mid_pipeline;
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'd11);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tests_run++;
    if (y96 !== 96'd121) begin
      failed++;
      $display("FAIL mid_pre got=%0d exp=121", y96);
    end
    tick(1'b1, 1'b1, 32'd7);
    tick(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, $urandom);
      tests_run++;
      if (y96 !== 96'd0 || y64 !== 64'd0) begin
        failed++;
        $display("FAIL mid_flush step=%0d got=%0d/%0d exp=0", i, y96, y64);
      end
    end
    tick(1'b1, 1'b1, 32'd6);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tests_run++;
    if (y96 !== 96'd0) begin
      failed++;
      $display("FAIL mid_flush2 got=%0d exp=0", y96);
    end
    tick(1'b0, 1'b1, 32'd9);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tests_run++;
    if (y96 !== 96'd0) begin
      failed++;
      $display("FAIL rst_priority got=%0d exp=0", y96);
    end
    tick(1'b1, 1'b1, 32'd4);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tests_run++;
    if (y96 !== 96'd16) begin
      failed++;
      $display("FAIL restart got=%0d exp=16", y96);
    end
    $display("[TB] test_reset_mid_pipeline done");
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    r   = 32'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_pulsed_random();
    test_random_stream();
    test_overflow();
    test_reset_mid_pipeline();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/circuit_unit.md
Name: circuit_unit

Overview:
- Pipelined sum-of-squares accumulator.
- On each enabled cycle it samples a signed 32-bit input sample, squares it, and adds the square into a W-bit running total that is presented on y.
- It is used as a signal-energy or statistics block fed by a stream of random or ADC-like samples.
- It accepts one sample per clock.

Parameters:
- W, 96, width of the accumulator and of output y. Must be ≥ 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low. rst=0 at a rising clk edge resets the block.
- en  input  1  sample-valid strobe; r is consumed at every rising edge where en=1.
- r  input  32  input sample, two's-complement signed.
- y  output  W  running accumulator, unsigned, registered.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-low.
- Reset effects:
  - y = 0.
  - Both pipeline valid flags = 0.
  - Pipeline data registers = 0.
  - Reset has priority over en.
- Pipeline stage 1, at edge N with en=1: r_q <= r, v1 <= 1. With en=0: v1 <= 0 and r_q holds.
- Pipeline stage 2, at edge N+1:
  - If v1=1: p_q <= r_q*r_q, computed as a signed 32x32 multiply. The result is non-negative and ≤ 2^62, held as a 64-bit unsigned value.
  - v2 <= v1.
- Accumulate, at edge N+2: if v2=1, y <= y + zero_extend_W(p_q), modulo 2^W. Otherwise y holds.
- Latency: a sample presented at edge N is reflected in y immediately after edge N+2.
- Throughput: en may be high on every cycle. Back-to-back samples each contribute exactly once, in order.
- When en=0, r is ignored entirely (don't-care, including X).
- Idle pipeline: y never changes when no valid sample is in flight.
- Overflow: default is wrap-around modulo 2^W; see Optional Feature.
- Reset mid-operation: samples already in the pipeline are discarded and never reach y. Accumulation restarts from 0 with the first en after rst returns high.
- Simultaneous en=1 and rst=0: reset wins and the sample is dropped.
- Extreme input: r = -2^31 yields a square of exactly 2^62, with no intermediate overflow.
- y is driven only from a register, with no combinational path from any input.

Optional Feature:
- Macro: CIRCUIT_SATURATE_EN.
- Defined: the accumulate step saturates. If y + p_q ≥ 2^W, y <= 2^W-1, and y then stays at all-ones until reset.
- Not defined: plain modulo-2^W wrap-around as described above.
- Pipeline timing is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 cycles with en=1, r=5 → y=0 throughout. Release rst, keep en=0 for 4 cycles → y stays 0.
- Single sample: en=1, r=3 for one cycle → y=0 after edges N and N+1, y=9 after edge N+2. Next, r=-5 → y=34 two cycles later.
- Back-to-back, every cycle: r=2047 then r=-2048 then r=0 → y steps 0 → 4190209 → 8384513 → 8384513, one step per cycle starting at N+2.
- Pulsed en with random r in [-2047,2047], 100 samples, en high every other cycle → final y equals the software sum of r² for those samples; no extra or missing accumulations.
- Overflow, W=64, r=-2^31 four times:
  - without CIRCUIT_SATURATE_EN → y = 2^62, 2^63, 3·2^62, 0;
  - with CIRCUIT_SATURATE_EN → the last value is 2^64-1, and y stays there after one further r=1.
- Reset mid-pipeline: en=1 with r=7 at edge N, rst=0 at edge N+1 → y remains 0 at N+2 and later, and the pipeline is empty after rst is released.
